// File: rtl/logic_alu_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic ALU.
package logic_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise function unit: one result plus its zero and odd-parity
// flags, so the flags can travel down the pipeline alongside the result.
module logic_op_core
  import logic_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  // Select the logic function, then derive both flags from the selected result.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    y      = '0;
    zero   = 1'b0;
    parity = 1'b0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = '0;
    endcase
    zero   = ~|y;
    parity = ^y;
  end

endmodule

// File: rtl/logic_alu_pipe.sv
// Elastic STAGES-deep pipeline around logic_op_core. All stages advance together
// whenever the output slot is empty or being drained; otherwise everything holds.
module logic_alu_pipe
  import logic_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  logic             adv;
  logic [WIDTH-1:0] core_y;
  logic             core_zero;
  logic             core_parity;

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [STAGES-1:0] zf;
  logic [STAGES-1:0] pf;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .y      (core_y),
    .zero   (core_zero),
    .parity (core_parity)
  );

  assign out_valid = vld[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = rst_n && adv;
  assign y         = dat[STAGES-1];
  assign zero      = zf[STAGES-1];
  assign parity    = pf[STAGES-1];

  // Valid bits: shift on advance so bubbles move out like real entries.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the shift does not collapse.
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
    end
  end

  // Payload: only loaded from a valid source, so y holds its last result
  // across bubbles and the flags always describe the value on y.
  always_ff @(posedge clk) begin
    // NOTE: the payload registers are reset because the cleared output value
    // is architecturally visible; plain data storage normally would not be.
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
      zf <= '0;
      pf <= '0;
    end else if (adv) begin
      if (in_valid) begin
        dat[0] <= core_y;
        zf[0]  <= core_zero;
        pf[0]  <= core_parity;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
          zf[i]  <= zf[i-1];
          pf[i]  <= pf[i-1];
        end
      end
    end
  end

  // Completed-transaction counter, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: doc/logic_alu_pipe.md
Name: logic_alu_pipe

Overview:
- Parametrised, pipelined successor to the two-input gate block.
- Takes WIDTH-bit operands a and b plus a 3-bit opcode, and computes one bitwise logic function per transaction.
- Results are delivered through a STAGES-deep valid/ready pipeline, together with zero and parity flags and a saturating transaction counter.
- Sits between an operand producer and a result consumer; both sides are elastic and must tolerate backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..64).
- STAGES, 2, pipeline depth in cycles from input handshake to result valid (legal range 1..4).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the clk rising edge.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  opcode: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a.
- out_valid  output  1  y and the flags hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- y  output  WIDTH  result.
- zero  output  1  asserted when y is all zeros.
- parity  output  1  XOR-reduction of y (odd parity).
- op_count  output  CNT_W  number of output handshakes completed since reset.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All stage valid bits, out_valid, y, zero, parity and op_count clear to 0.
  - in_ready is 0 while rst_n is low.
  - Reset mid-operation discards all in-flight results, with no partial output.
- Handshakes:
  - Input transfer occurs when in_valid and in_ready are both high.
  - Output transfer occurs when out_valid and out_ready are both high.
- Global advance:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational, while rst_n is high).
  - When adv is 1, every stage shifts forward by one and stage 0 captures {in_valid, result, flags}.
  - When adv is 0, all stages hold their contents.
- Latency:
  - A transaction accepted at edge N presents out_valid=1 after edge N+STAGES-1.
  - With STAGES=1, it appears on the cycle immediately after acceptance.
  - Throughput is 1 per cycle when out_ready is held high.
- Compute:
  - The result is computed combinationally from a, b and op at acceptance and registered into stage 0.
  - Later stages only carry it; no recompute.
  - NOT and PASS ignore b.
- Flags: zero and parity are computed from the same result and travel with it, so they are always consistent with y.
- Output holding: while out_valid=1 and out_ready=0, y, zero, parity and out_valid must stay stable (AXI-style hold).
- Bubbles: empty stages (valid=0) shift out normally and never produce out_valid.
- Simultaneous events: an input and an output handshake in the same cycle are both legal; occupancy is unchanged.
- op_count:
  - Increments by 1 on each output handshake.
  - Saturates at 2^CNT_W-1; no wrap.
- Data masking: y holds its last value when out_valid=0 (no requirement to zero it), but zero and parity must still match y.

Decomposition:
- Package logic_alu_pkg holds:
  - the op_e enum (OP_AND..OP_PASS, 3 bits);
  - the constant OP_W=3.
- Sub-module logic_op_core: purely combinational, WIDTH-parametrised.
  - Inputs: a, b, op.
  - Outputs: y, zero, parity.
  - Instantiated once at the pipeline input.
- The top level contains only the stage registers, the advance logic and the counter.

Test Plan:
- Opcode sweep: WIDTH=8, STAGES=2, out_ready=1, a=8'hA5, b=8'h3C, op=0..7 back-to-back.
  - y sequence = 24, BD, 5A, DB, 42, 99, 66, A5.
  - Each result appears 2 cycles after acceptance.
  - parity for the sequence = 0,0,0,0,0,0,0,0.
  - op_count ends at 8.
- Zero flag: a=8'h0F, b=8'hF0, op=AND.
  - Expect y=00, zero=1, parity=0.
  - Same operands with op=XOR: y=FF, zero=0, parity=0.
- Backpressure:
  - Stream 4 transactions, drop out_ready for 3 cycles with out_valid high.
  - y must stay stable, in_ready=0 and no transaction lost or duplicated.
  - After release, all 4 arrive in order and op_count=4.
- Reset mid-operation:
  - Accept 2 transactions, assert rst_n=0 for 1 cycle before any output.
  - out_valid stays 0 afterwards and op_count=0.
  - A new transaction completes normally.
- Counter saturation: CNT_W=2, run 6 handshakes -> op_count reads 1,2,3,3,3,3.
- Parametric: STAGES=1 and STAGES=4 at WIDTH=1 and WIDTH=32, using random op/a/b with random out_ready.
  - Results must match the reference model in order, with latency exactly STAGES when unstalled.
